// File: rtl/simple_chk_pkg.sv
// Shared types and default parameters for the simple counter/shift pattern checker.
// The optional SIMPLE_CHK_FIRST_ERR_EN macro (see top) adds first-mismatch capture.
package simple_chk_pkg;

  typedef enum logic [0:0] {
    CHK_UNLOCKED,
    CHK_LOCKED
  } chk_state_e;

  localparam int DEF_CNT_W      = 2;
  localparam int DEF_SHIFT_W    = 127;
  localparam int DEF_LOCK_BEATS = 2;
  localparam int DEF_ERR_CNT_W  = 16;
  localparam int BEAT_CNT_W     = 32;

endpackage

// File: rtl/simple_chk_predictor.sv
// Combinational generator law: next count and next shift from the last accepted beat.
// Shift fills with ones from the bottom two bits and saturates at all-ones.
module simple_chk_predictor #(
  parameter int CNT_W   = 2,
  parameter int SHIFT_W = 127
) (
  input  logic [CNT_W-1:0]   ref_count,
  input  logic [SHIFT_W-1:0] ref_shift,
  output logic [CNT_W-1:0]   exp_count,
  output logic [SHIFT_W-1:0] exp_shift
);

  assign exp_count = ref_count + 1'b1;

  if (SHIFT_W < 2) begin : g_bad_w
    $error("simple_chk_predictor: SHIFT_W must be >= 2");
  end else if (SHIFT_W == 2) begin : g_w2
    assign exp_shift = 2'b11;
  end else begin : g_wn
    assign exp_shift = {ref_shift[SHIFT_W-3:0], 2'b11};
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, ref_shift[SHIFT_W-1 -: 2]};

endmodule

// File: rtl/simple_pattern_checker.sv
// Lock-and-check monitor for the {count, shift} benchmark stimulus stream.
// Define SIMPLE_CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module simple_pattern_checker
  import simple_chk_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SHIFT_W    = DEF_SHIFT_W,
  parameter int LOCK_BEATS = DEF_LOCK_BEATS,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CNT_W-1:0]      in_count,
  input  logic [SHIFT_W-1:0]    in_shift,
  input  logic                  err_clr,
  output logic                  locked,
  output logic                  err,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt,
`ifdef SIMPLE_CHK_FIRST_ERR_EN
  output logic [CNT_W-1:0]      first_err_exp_count,
  output logic [CNT_W-1:0]      first_err_act_count,
  output logic                  first_err_valid,
`endif
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam int RUN_W = $clog2(LOCK_BEATS + 1);
  localparam logic [RUN_W-1:0] LOCK_R = RUN_W'(LOCK_BEATS);
  localparam logic [RUN_W-1:0] RUN_1  = RUN_W'(1);

  if (LOCK_BEATS < 1) begin : g_bad_lock
    $error("simple_pattern_checker: LOCK_BEATS must be >= 1");
  end

  chk_state_e         state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   ref_count;
  logic [SHIFT_W-1:0] ref_shift;
  logic [CNT_W-1:0]   exp_count;
  logic [SHIFT_W-1:0] exp_shift;
  logic               cons;
  logic               err_d;
  logic               bc_inc;
  logic [ERR_CNT_W-1:0] ec_base, ec_d;

  simple_chk_predictor #(
    .CNT_W   (CNT_W),
    .SHIFT_W (SHIFT_W)
  ) u_pred (
    .ref_count (ref_count),
    .ref_shift (ref_shift),
    .exp_count (exp_count),
    .exp_shift (exp_shift)
  );

  assign cons = (in_count == exp_count) && (in_shift == exp_shift);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = 1'b0;
    bc_inc  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        CHK_UNLOCKED: begin
          run_d = (run_q == '0 || !cons) ? RUN_1 : run_q + 1'b1;
          if (run_d == LOCK_R) state_d = CHK_LOCKED;
        end
        CHK_LOCKED: begin
          if (cons) begin
            bc_inc = 1'b1;
          end else begin
            err_d   = 1'b1;
            run_d   = RUN_1;
            state_d = CHK_UNLOCKED;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear lands before the increment so a racing mismatch counts as one.
  always_comb begin
    ec_base = err_clr ? '0 : err_cnt;
    ec_d    = ec_base;
    unique case (1'b1)
      err_d && (ec_base != '1): ec_d = ec_base + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CHK_UNLOCKED;
      run_q      <= '0;
      ref_count  <= '0;
      ref_shift  <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      err        <= err_d;
      err_sticky <= err_d | (err_sticky & ~err_clr);
      err_cnt    <= ec_d;
      if (in_valid) begin
        ref_count <= in_count;
        ref_shift <= in_shift;
      end
      if (bc_inc) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign locked = (state_q == CHK_LOCKED);

`ifdef SIMPLE_CHK_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_valid     <= 1'b0;
      first_err_exp_count <= '0;
      first_err_act_count <= '0;
    end else if (err_d && (err_clr || !first_err_valid)) begin
      first_err_valid     <= 1'b1;
      first_err_exp_count <= exp_count;
      first_err_act_count <= in_count;
    end else if (err_clr) begin
      first_err_valid     <= 1'b0;
      first_err_exp_count <= '0;
      first_err_act_count <= '0;
    end
  end
`endif

endmodule
